// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serializer and the detector stages fed by it.
//   state_t    : two-state FSM encoding (IDLE=0, SHIFT=1)
//   WORD_CNT_W : width of the completed-word counter
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned WORD_CNT_W = 8;

endpackage

// File: rtl/piso_shift_core.sv
// Shift register plus bit counter for the parallel-in/serial-out path.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture din, restart the bit counter at 0
//   shift      : advance one bit (ignored when load is high)
//   din        : parallel word
//   last       : the bit currently presented is the final one of the word
//   bit_nxt    : bit that will be at the head after this edge
//   last_nxt   : that head bit will be the final one of the word
module piso_shift_core #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             last,
  output logic             bit_nxt,
  output logic             last_nxt
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_cnt;
    if (load) begin
      w_sreg_nxt = din;
      w_cnt_nxt  = '0;
    end else if (shift) begin
      // The head bit is always at the send-first end; shift toward it.
      w_sreg_nxt = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
      w_cnt_nxt  = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign bit_nxt  = MSB_FIRST ? w_sreg_nxt[WIDTH-1] : w_sreg_nxt[0];
  assign last_nxt = (w_cnt_nxt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready input handshake.
//   clk, rst    : clock, asynchronous active-high reset
//   din         : parallel word, transferred when din_valid && din_ready
//   din_valid   : upstream has a word
//   din_ready   : combinational; high in IDLE or while the last bit is out
//   sout        : registered serial bit (IDLE_BIT when not sending)
//   sout_valid  : registered, sout carries a data bit
//   sout_last   : registered, sout carries the final bit of a word
//   word_cnt    : completed words, wraps modulo 256
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  sout_last,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  state_t                r_state;
  logic                  r_sout;
  logic                  r_sout_valid;
  logic                  r_sout_last;
  logic [WORD_CNT_W-1:0] r_word_cnt;

  logic w_core_last;
  logic w_bit_nxt;
  logic w_last_nxt;
  logic w_last_act;
  logic w_xfer;
  logic w_shift;

  assign w_last_act = (r_state == SHIFT) && w_core_last;
  assign din_ready  = (r_state == IDLE) || w_last_act;
  assign w_xfer     = din_valid && din_ready;
  assign w_shift    = (r_state == SHIFT) && !w_core_last;

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (w_xfer),
    .shift    (w_shift),
    .din      (din),
    .last     (w_core_last),
    .bit_nxt  (w_bit_nxt),
    .last_nxt (w_last_nxt)
  );

  // Outputs are loaded with the value the shift core will hold after this
  // edge, so sout tracks the head bit without a combinational path from din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sout       <= IDLE_BIT;
      r_sout_valid <= 1'b0;
      r_sout_last  <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_state      <= SHIFT;
            r_sout       <= w_bit_nxt;
            r_sout_valid <= 1'b1;
            r_sout_last  <= w_last_nxt;
          end else begin
            r_sout       <= IDLE_BIT;
            r_sout_valid <= 1'b0;
            r_sout_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_core_last) begin
            r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
          end
          if (!w_core_last || w_xfer) begin
            r_sout       <= w_bit_nxt;
            r_sout_valid <= 1'b1;
            r_sout_last  <= w_last_nxt;
          end else begin
            r_state      <= IDLE;
            r_sout       <= IDLE_BIT;
            r_sout_valid <= 1'b0;
            r_sout_last  <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_sout       <= IDLE_BIT;
          r_sout_valid <= 1'b0;
          r_sout_last  <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign sout_last  = r_sout_last;
  assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first instance (IDLE_BIT=0) and an
// LSB-first instance (IDLE_BIT=1) driven by the same handshake, compared
// each cycle against a queue-of-pending-bits reference model.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;

  logic       din_ready, sout, sout_valid, sout_last;
  logic [7:0] word_cnt;
  logic       din_ready_l, sout_l, sout_valid_l, sout_last_l;
  logic [7:0] word_cnt_l;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  piso_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1),
    .IDLE_BIT  (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .word_cnt   (word_cnt)
  );

  piso_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0),
    .IDLE_BIT  (1'b1)
  ) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready_l),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .sout_last  (sout_last_l),
    .word_cnt   (word_cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits still to appear on sout, head = bit on sout now.
  bit          q_msb[$];
  bit          q_lsb[$];
  int unsigned m_cnt = 0;
  bit          m_acc = 0;
  logic [7:0]  tx_words[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_msb.delete();
    q_lsb.delete();
    m_cnt = 0;
    m_acc = 0;
  endtask

  // One rising edge: the head bit is consumed, then an accepted word is queued.
  task automatic model_edge(input logic v, input logic [7:0] d);
    bit ready;
    ready = (q_msb.size() <= 1);
    m_acc = v && ready;
    if (q_msb.size() > 0) begin
      if (q_msb.size() == 1) m_cnt = (m_cnt + 1) % 256;
      void'(q_msb.pop_front());
      void'(q_lsb.pop_front());
    end
    if (m_acc) begin
      for (int i = 0; i < 8; i++) begin
        q_msb.push_back(d[7-i]);
        q_lsb.push_back(d[i]);
      end
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (q_msb.size() > 0);
    check_eq("sout_valid", {31'b0, sout_valid}, {31'b0, v});
    check_eq("sout", {31'b0, sout}, {31'b0, v ? q_msb[0] : 1'b0});
    check_eq("sout_last", {31'b0, sout_last}, {31'b0, q_msb.size() == 1});
    check_eq("din_ready", {31'b0, din_ready}, {31'b0, q_msb.size() <= 1});
    check_eq("word_cnt", {24'b0, word_cnt}, m_cnt);
    check_eq("lsb_sout", {31'b0, sout_l}, {31'b0, v ? q_lsb[0] : 1'b1});
    check_eq("lsb_valid_last", {30'b0, sout_valid_l, sout_last_l},
             {30'b0, v, q_lsb.size() == 1});
    check_eq("lsb_ready_cnt", {23'b0, din_ready_l, word_cnt_l},
             {23'b0, q_lsb.size() <= 1, 8'(m_cnt)});
  endtask

  // Called at a falling edge: drive, take the rising edge, check at next fall.
  task automatic cycle(input logic v, input logic [7:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_words(input int unsigned gap_pct);
    int unsigned idx;
    int unsigned guard;
    logic        v;
    idx   = 0;
    guard = 0;
    while ((idx < tx_words.size() || q_msb.size() > 0) && guard < 20000) begin
      v = (idx < tx_words.size()) && ($urandom_range(99) >= gap_pct);
      cycle(v, (idx < tx_words.size()) ? tx_words[idx] : 8'h00);
      if (m_acc) idx++;
      guard++;
    end
    check_eq("send_done", {31'b0, guard < 20000}, 32'd1);
    tx_words.delete();
  endtask

  initial begin
    int unsigned c0;
    int unsigned det;
    int unsigned det_idx;
    int unsigned bit_idx;
    logic [2:0]  hist;

    rst       = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    check_eq("rst_ready", {31'b0, din_ready}, 32'd1);
    rst = 1'b0;

    // A5 MSB-first (first transfer on first edge after release)
    tx_words.push_back(8'hA5);
    send_words(0);
    check_eq("a5_word_cnt", {24'b0, word_cnt}, 32'd1);

    // Back-to-back FF then 00 with valid held high
    tx_words.push_back(8'hFF);
    tx_words.push_back(8'h00);
    send_words(0);
    check_eq("b2b_word_cnt", {24'b0, word_cnt}, 32'd3);

    // Reset asserted while bit 4 of C3 is on sout
    cycle(1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_outs", {28'b0, sout, sout_valid, sout_last, din_ready}, 32'h1);
    check_eq("midrst_cnt", {24'b0, word_cnt}, 32'd0);
    check_eq("midrst_lsb_sout", {31'b0, sout_l}, 32'd1);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    cycle(1'b1, 8'h81);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00);
    check_eq("after_rst_cnt", {24'b0, word_cnt}, 32'd1);

    // Random words with random idle gaps
    for (int i = 0; i < 60; i++) tx_words.push_back(8'($urandom));
    send_words(30);

    // 256 words back-to-back: counter returns to its start value
    c0 = m_cnt;
    for (int i = 0; i < 256; i++) tx_words.push_back(8'($urandom));
    send_words(0);
    check_eq("wrap_cnt", {24'b0, word_cnt}, c0);

    // 05 into a 101 detector: one hit, on bit 8
    det     = 0;
    det_idx = 0;
    bit_idx = 0;
    hist    = 3'b000;
    for (int i = 0; i < 9; i++) begin
      cycle(i == 0, 8'h05);
      if (sout_valid) begin
        hist = {hist[1:0], sout};
        bit_idx++;
        if (bit_idx >= 3 && hist == 3'b101) begin
          det++;
          det_idx = bit_idx;
        end
      end
    end
    check_eq("det_count", det, 32'd1);
    check_eq("det_bit", det_idx, 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
